// File: rtl/strb_mem_pkg.sv
// Shared types and helpers for the strobe/acknowledge memory slave.
// Holds the transfer FSM state type, the wait-state ceiling and the lane-count helper.
package strb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } state_t;

   localparam int MAX_WAIT = 15;

   function automatic int lane_count(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/strb_mem_array.sv
// DEPTH x DW synchronous storage with per-byte-lane write enables and a registered read port.
// Contents are deliberately not reset.
module strb_mem_array
   import strb_mem_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 256,
   parameter int IW    = 8
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [lane_count(DW)-1:0] be,
   input  logic [IW-1:0]            addr,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata
);

   localparam int NL = lane_count(DW);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < NL; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/strb_mem_slave.sv
// Strobe/acknowledge memory target: request capture, optional wait states, one-cycle ack,
// byte-lane writes and an error response for addresses beyond DEPTH.
module strb_mem_slave
   import strb_mem_pkg::*;
#(
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      strb,
   input  logic                      we,
   input  logic [lane_count(DW)-1:0] be,
   input  logic [AW-1:0]             addr,
   input  logic [DW-1:0]             wdata,
   output logic [DW-1:0]             rdata,
   output logic                      ack,
   output logic                      err
);

   localparam int NL = lane_count(DW);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DW % 8 != 0) begin : g_dw_check
      $error("strb_mem_slave: DW must be a multiple of 8");
   end
   if (DEPTH > (2 ** AW)) begin : g_depth_check
      $error("strb_mem_slave: DEPTH must not exceed 2**AW");
   end
   if ((WAIT_STATES < 0) || (WAIT_STATES > MAX_WAIT)) begin : g_wait_check
      $error("strb_mem_slave: WAIT_STATES must be in 0..15");
   end

   state_t        state, state_nxt;
   logic [3:0]    wcnt, wcnt_nxt;
   logic          go_ack;

   logic          we_q;
   logic [NL-1:0] be_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          err_q;

   logic          cur_we;
   logic [NL-1:0] cur_be;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata;
   logic          cur_oor;
   logic [DW-1:0] arr_rdata;

   // With zero wait states the commit edge is the capture edge, so the live bus feeds the array.
   assign cur_we    = (state == IDLE) ? we    : we_q;
   assign cur_be    = (state == IDLE) ? be    : be_q;
   assign cur_addr  = (state == IDLE) ? addr  : addr_q;
   assign cur_wdata = (state == IDLE) ? wdata : wdata_q;
   assign cur_oor   = ({1'b0, cur_addr} >= (AW + 1)'(DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      go_ack    = 1'b0;
      ack       = 1'b0;
      err       = 1'b0;
      rdata     = '0;
      unique case (state)
         IDLE: begin
            if (strb) begin
               wcnt_nxt = 4'(WAIT_STATES);
               if (WAIT_STATES > 0) begin
                  state_nxt = WAIT;
               end else begin
                  state_nxt = ACK;
                  go_ack    = 1'b1;
               end
            end
         end
         WAIT: begin
            wcnt_nxt = wcnt - 4'd1;
            if (wcnt == 4'd1) begin
               state_nxt = ACK;
               go_ack    = 1'b1;
            end
         end
         ACK: begin
            state_nxt = IDLE;
            ack       = 1'b1;
            err       = err_q;
            rdata     = (err_q || we_q) ? '0 : arr_rdata;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state == IDLE) && strb) begin
            we_q    <= we;
            be_q    <= be;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (go_ack) begin
            err_q <= cur_oor;
         end
      end
   end

   strb_mem_array #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk   (clk),
      .en    (go_ack && !cur_oor),
      .we    (cur_we),
      .be    (cur_be),
      .addr  (cur_addr[IW-1:0]),
      .wdata (cur_wdata),
      .rdata (arr_rdata)
   );

endmodule
